// File: rtl/inv_mixcolumns_iter.sv
// Iterative AES InvMixColumns engine: accepts a 128-bit state, rewrites it in
// place COLS_PER_CYCLE columns per clock and returns it over a valid/ready pair.
module inv_mixcolumns_iter #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic         in_bypass,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data
);

    localparam int STEPS = 4 / COLS_PER_CYCLE;
    localparam logic [1:0] LAST_STEP = 2'(STEPS - 1);

    if (!((COLS_PER_CYCLE == 1) || (COLS_PER_CYCLE == 2) || (COLS_PER_CYCLE == 4))) begin : g_bad_cols
        $error("inv_mixcolumns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ ({8{b[7]}} & 8'h1b);
    endfunction

    // One column: multiples 9/B/D/E are built from the x2/x4/x8 chain.
    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a   [4];
        logic [7:0] m9  [4];
        logic [7:0] mb  [4];
        logic [7:0] md  [4];
        logic [7:0] me  [4];
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        for (int r = 0; r < 4; r++) begin
            a[r]  = col[31-8*r -: 8];
            x2    = xtime(a[r]);
            x4    = xtime(x2);
            x8    = xtime(x4);
            m9[r] = x8 ^ a[r];
            mb[r] = x8 ^ x2 ^ a[r];
            md[r] = x8 ^ x4 ^ a[r];
            me[r] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    state_t         r_state;
    state_t         w_state_nxt;
    logic [1:0]     r_cnt;
    logic [127:0]   r_data;
    logic           r_bypass;
    logic           r_in_ready;
    logic           r_out_valid;
    logic           w_load;
    logic           w_step;
    logic [127:0]   w_data_nxt;

    // Next-state and datapath control decode.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_state_nxt = S_BUSY;
                    w_load      = 1'b1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_BUSY: begin
                w_step = 1'b1;
                if (r_cnt == LAST_STEP) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_BUSY;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_DONE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Transform the columns selected by the step counter; others pass through.
    always_comb begin
        int idx;
        idx        = 0;
        w_data_nxt = r_data;
        for (int g = 0; g < COLS_PER_CYCLE; g++) begin
            idx = int'(r_cnt) * COLS_PER_CYCLE + g;
            w_data_nxt[(3-idx)*32 +: 32] = inv_mix_col(r_data[(3-idx)*32 +: 32]);
        end
    end

    // State register with handshake flags registered alongside it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= (w_state_nxt == S_IDLE);
            r_out_valid <= (w_state_nxt == S_DONE);
        end
    end

    // Data register, bypass flag and step counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data   <= 128'd0;
            r_bypass <= 1'b0;
            r_cnt    <= 2'd0;
        end else if (w_load) begin
            r_data   <= in_data;
            r_bypass <= in_bypass;
            r_cnt    <= 2'd0;
        end else if (w_step) begin
            if (!r_bypass) begin
                r_data <= w_data_nxt;
            end
            if (r_cnt != LAST_STEP) begin
                r_cnt <= r_cnt + 2'd1;
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_data;

endmodule

// File: tb/tb_inv_mixcolumns_iter.sv
// Directed and random checks of inv_mixcolumns_iter at 1, 2 and 4 columns/cycle.
module tb_inv_mixcolumns_iter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, in_valid, in_bypass, out_ready;
    logic [127:0] in_data;
    logic         in_ready1, in_ready2, in_ready4;
    logic         out_valid1, out_valid2, out_valid4;
    logic [127:0] out_data1, out_data2, out_data4;

    inv_mixcolumns_iter #(.COLS_PER_CYCLE(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .in_data(in_data), .in_bypass(in_bypass), .out_valid(out_valid1),
        .out_ready(out_ready), .out_data(out_data1));
    inv_mixcolumns_iter #(.COLS_PER_CYCLE(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .in_data(in_data), .in_bypass(in_bypass), .out_valid(out_valid2),
        .out_ready(out_ready), .out_data(out_data2));
    inv_mixcolumns_iter #(.COLS_PER_CYCLE(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
        .in_data(in_data), .in_bypass(in_bypass), .out_valid(out_valid4),
        .out_ready(out_ready), .out_data(out_data4));

    localparam logic [127:0] V1 = 128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6;
    localparam logic [127:0] R1 = 128'hdb135345_f20a225c_01010101_d4d4d4d5;
    localparam logic [127:0] V2 = 128'h4d7ebdf8_c6c6c6c6_8e4da1bc_9fdc589d;
    localparam logic [127:0] R2 = 128'h2d26314c_c6c6c6c6_db135345_f20a225c;
    localparam logic [127:0] V3 = 128'h01234567_89abcdef_fedcba98_76543210;

    int           n_total = 0;
    int           n_fail  = 0;
    int           lat1, lat2, lat4, lat;
    logic [127:0] od1, od2, od4, got, d;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
        end
        return p;
    endfunction

    // Applies a circulant matrix with first row m0 m1 m2 m3 to every column.
    function automatic logic [127:0] mix(input logic [127:0] s, input logic [7:0] m0,
                                         input logic [7:0] m1, input logic [7:0] m2,
                                         input logic [7:0] m3);
        logic [127:0] o = 128'd0;
        logic [7:0]   m [4];
        logic [7:0]   a [4];
        m[0] = m0; m[1] = m1; m[2] = m2; m[3] = m3;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) a[r] = s[127-32*c-8*r -: 8];
            for (int r = 0; r < 4; r++)
                o[127-32*c-8*r -: 8] = gmul(m[(4-r)%4], a[0]) ^ gmul(m[(5-r)%4], a[1])
                                     ^ gmul(m[(6-r)%4], a[2]) ^ gmul(m[(7-r)%4], a[3]);
        end
        return o;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [127:0] data, input logic byp);
        in_data   = data;
        in_bypass = byp;
        in_valid  = 1'b1;
        tick();
        in_valid  = 1'b0;
        in_bypass = 1'b0;
    endtask

    // Sends one block to all three engines and records when each output appears.
    task automatic run_all(input logic [127:0] data, input logic byp);
        send(data, byp);
        lat1 = 0; lat2 = 0; lat4 = 0;
        od1 = 128'd0; od2 = 128'd0; od4 = 128'd0;
        for (int k = 1; k <= 8; k++) begin
            if (out_valid1 && lat1 == 0) begin lat1 = k; od1 = out_data1; end
            if (out_valid2 && lat2 == 0) begin lat2 = k; od2 = out_data2; end
            if (out_valid4 && lat4 == 0) begin lat4 = k; od4 = out_data4; end
            tick();
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_bypass = 1'b0; out_ready = 1'b1; in_data = 128'd0;
        tick();
        tick();
        chk("reset_in_ready", 128'(in_ready1), 128'd1);
        chk("reset_out_valid", 128'(out_valid1), 128'd0);
        chk("reset_out_data", out_data1, 128'd0);
        rst = 1'b0;
        tick();

        run_all(V1, 1'b0);
        chk("single_lat", 128'(lat1), 128'd5);
        chk("single_data", od1, R1);

        run_all(V2, 1'b0);
        chk("rt_lat1", 128'(lat1), 128'd5);
        chk("rt_lat2", 128'(lat2), 128'd3);
        chk("rt_lat4", 128'(lat4), 128'd2);
        chk("rt_data1", od1, R2);
        chk("rt_data2", od2, R2);
        chk("rt_data4", od4, R2);

        run_all(V3, 1'b1);
        chk("byp_lat1", 128'(lat1), 128'd5);
        chk("byp_data1", od1, V3);
        chk("byp_lat4", 128'(lat4), 128'd2);
        chk("byp_data4", od4, V3);

        out_ready = 1'b0;
        send(V1, 1'b0);
        repeat (4) tick();
        chk("bp_valid", 128'(out_valid1), 128'd1);
        chk("bp_data", out_data1, R1);
        in_data  = V2;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_hold_valid", 128'(out_valid1), 128'd1);
            chk("bp_hold_data", out_data1, R1);
            chk("bp_hold_in_ready", 128'(in_ready1), 128'd0);
        end
        out_ready = 1'b1;
        tick();
        chk("bp_release_in_ready", 128'(in_ready1), 128'd1);
        chk("bp_release_out_valid", 128'(out_valid1), 128'd0);
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid1 && lat < 20) begin tick(); lat++; end
        chk("bp_second_lat", 128'(lat), 128'd5);
        chk("bp_second_data", out_data1, R2);
        tick();

        send(V1, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_in_ready", 128'(in_ready1), 128'd1);
        chk("mid_rst_out_valid", 128'(out_valid1), 128'd0);
        chk("mid_rst_out_data", out_data1, 128'd0);
        run_all(V2, 1'b0);
        chk("post_rst_lat", 128'(lat1), 128'd5);
        chk("post_rst_data", od1, R2);

        out_ready = 1'b0;
        for (int n = 0; n < 1000; n++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            repeat ($urandom_range(0, 2)) tick();
            send(d, 1'b0);
            lat = 0;
            while (!out_valid1 && lat < 20) begin tick(); lat++; end
            got = out_data1;
            repeat ($urandom_range(0, 2)) tick();
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            chk("rand_model", got, mix(d, 8'h0e, 8'h0b, 8'h0d, 8'h09));
            chk("rand_fwd_inverse", mix(got, 8'h02, 8'h03, 8'h01, 8'h01), d);
        end

        $display("%0d/%0d checks passed", n_total - n_fail, n_total);
        $finish;
    end

endmodule
